// File: rtl/mac_inverse.sv
// Recovers A from D = A*B + C by restoring division: quot = (D - C) / B, rem = (D - C) mod B.
// Optional early-exit error detection (B == 0, D < C) is enabled by defining MAC_INVERSE_ERR_EN.
module mac_inverse #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OUT_W-1:0] data_in,
    input  logic [IN_W-1:0]  b,
    input  logic [IN_W-1:0]  c,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] quot,
    output logic [IN_W-1:0]  rem,
    output logic             err_div0,
    output logic             err_under
);

    localparam int CNT_W = $clog2(OUT_W);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   d_r;
    logic [IN_W-1:0]    b_r;
    logic [IN_W-1:0]    c_r;
    logic [OUT_W-1:0]   dvd_r;
    logic [IN_W:0]      prem_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_exit;
    logic               b_zero;
    logic               d_lt_c;
    logic [IN_W+1:0]    step;

    // One restoring step: returns {next partial remainder, quotient bit}.
    function automatic logic [IN_W+1:0] div_step(input logic [IN_W:0]   prem,
                                                 input logic            bit_in,
                                                 input logic [IN_W-1:0] dvs);
        logic [IN_W:0] trial;
        trial = {prem[IN_W-1:0], bit_in};
        if (trial >= {1'b0, dvs})
            div_step = {trial - {1'b0, dvs}, 1'b1};
        else
            div_step = {trial, 1'b0};
    endfunction

    assign b_zero = (b_r == '0);
    assign d_lt_c = (d_r < {{(OUT_W-IN_W){1'b0}}, c_r});
    assign step   = div_step(prem_r, dvd_r[OUT_W-1], b_r);

`ifdef MAC_INVERSE_ERR_EN
    assign err_exit = b_zero || d_lt_c;
`else
    assign err_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = err_exit ? DONE : DIV;
            DIV:  if (cnt_r == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Dividend register doubles as the quotient shift register: MSB out, quotient bit in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r    <= '0;
            b_r    <= '0;
            c_r    <= '0;
            dvd_r  <= '0;
            prem_r <= '0;
            cnt_r  <= '0;
            quot   <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_r <= data_in;
                        b_r <= b;
                        c_r <= c;
                    end
                end
                LOAD: begin
                    if (err_exit) begin
                        quot <= '0;
                        rem  <= '0;
                    end else begin
                        dvd_r  <= d_r - {{(OUT_W-IN_W){1'b0}}, c_r};
                        prem_r <= '0;
                        cnt_r  <= CNT_W'(OUT_W-1);
                    end
                end
                DIV: begin
                    dvd_r  <= {dvd_r[OUT_W-2:0], step[0]};
                    prem_r <= step[IN_W+1:1];
                    cnt_r  <= cnt_r - 1'b1;
                    if (cnt_r == '0) begin
                        quot <= {dvd_r[OUT_W-2:0], step[0]};
                        rem  <= step[IN_W:1];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_INVERSE_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_div0  <= 1'b0;
            err_under <= 1'b0;
        end else if (state == LOAD && err_exit) begin
            err_div0  <= b_zero;
            err_under <= !b_zero && d_lt_c;
        end else if (state == DIV && cnt_r == '0) begin
            err_div0  <= 1'b0;
            err_under <= 1'b0;
        end
    end
`else
    assign err_div0  = 1'b0;
    assign err_under = 1'b0;
`endif

endmodule

// File: doc/mac_inverse.md
MAC_INVERSE -- requirements
Module: mac_inverse

Interface
REQ-001 Parameter IN_W, default 8: width of operand inputs b, c and remainder output rem.
REQ-002 Parameter OUT_W, default 16: width of data_in and quot; SHALL equal 2*IN_W.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin one operation; sampled only in IDLE.
REQ-006 data_in  input  OUT_W  unsigned value D produced by the multiply-accumulate path (D = A*B + C).
REQ-007 b  input  IN_W  unsigned multiplier B; used as divisor.
REQ-008 c  input  IN_W  unsigned addend C; subtracted from D before division.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; results valid from this cycle onward.
REQ-011 quot  output  OUT_W  recovered A = (D - C) / B, unsigned integer quotient.
REQ-012 rem  output  IN_W  (D - C) mod B.
REQ-013 err_div0  output  1  B was zero for the completed operation.
REQ-014 err_under  output  1  D < C for the completed operation.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, DIV, DONE; busy = (state != IDLE).
REQ-016 IDLE with start=1 at a clock edge: latch data_in, b, c into internal registers; go to LOAD; input changes afterward SHALL have no effect.
REQ-017 LOAD (one cycle): form dividend = D - C as an OUT_W-bit unsigned value; if an error condition applies (REQ-026), go to DONE; otherwise clear partial remainder, load bit counter with OUT_W-1, go to DIV.
REQ-018 DIV: restoring shift-subtract, one quotient bit per cycle, MSB first; partial remainder held in IN_W+1 bits; after the bit at index 0 is resolved, go to DONE.
REQ-019 DONE (one cycle): done=1, update quot, rem, err_div0 and err_under together, return to IDLE.
REQ-020 Latency: start accepted at edge k -> done high in the cycle following edge k+1+OUT_W, i.e. OUT_W+2 cycles (18 at defaults); error exit -> done in the cycle following edge k+1, i.e. 2 cycles.
REQ-021 start asserted in LOAD, DIV or DONE SHALL be ignored and not queued; start held high continuously SHALL begin a new operation on the first edge in IDLE.
REQ-022 quot, rem and error flags SHALL hold their values until the next DONE; they SHALL NOT change during LOAD or DIV.
REQ-023 For error-free operands, quot*B + rem SHALL equal D - C exactly, and rem < B.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, quot=0, rem=0, err_div0=0, err_under=0, and clear all internal registers, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; first start accepted after rst_n rises SHALL behave as from power-up.

Configuration
REQ-026 Macro MAC_INVERSE_ERR_EN defined: in LOAD, B=0 sets err_div0=1; otherwise D<C sets err_under=1; either one exits early with quot=0, rem=0; B=0 takes priority when both apply.
REQ-027 Macro MAC_INVERSE_ERR_EN undefined: err_div0 and err_under SHALL be constant 0; no early exit; D<C wraps modulo 2^OUT_W; B=0 yields quot=all ones, rem=dividend low IN_W bits; latency always OUT_W+2.

Verification (IN_W=8, OUT_W=16)
REQ-028 data_in=1234, b=12, c=34, start pulse -> busy next cycle, done 18 cycles after the start edge, quot=100, rem=0, no error flags.
REQ-029 data_in=1000, b=7, c=5 -> quot=142, rem=1; data_in=65535, b=255, c=0 -> quot=257, rem=0.
REQ-030 With MAC_INVERSE_ERR_EN: b=0 -> done after 2 cycles, err_div0=1, quot=0; data_in=10, b=3, c=20 -> err_under=1, quot=0, rem=0.
REQ-031 Without MAC_INVERSE_ERR_EN: data_in=100, b=0, c=0 -> quot=0xFFFF, rem=0x64, flags 0, latency 18.
REQ-032 Second start pulse and changed data_in 5 cycles into an operation -> first result unaffected, exactly one done pulse.
REQ-033 rst_n low at cycle 8 of an operation -> all outputs 0 immediately, no done; a new operation after release gives the correct result.
